fetch_align_ctrl: RTL and testbench

Fetch-side sequencer between the PC/fetch stage and the instruction cache/prefetch port for the C extension. It issues word-aligned fetch requests and buffers the last fetched word plus one straddling halfword. It extracts 16-bit or 32-bit instructions at any halfword-aligned PC and presents them to the decode boundary through a valid/ready register. It absorbs redirects from EXE/CSR by killing the outstanding request and restarting at the new PC.

---
 rtl/fetch_align_ctrl_pkg.sv | 22 ++
 rtl/fetch_align_ctrl_halfword_extract.sv | 28 ++
 rtl/fetch_align_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_fetch_align_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_align_ctrl_pkg.sv
// Shared C-extension fetch definitions: state encoding, widths, NOP and the compressed predicate.
package fetch_align_ctrl_pkg;

  localparam int unsigned ILEN   = 32;
  localparam int unsigned HALF_W = 16;

  localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    FETCH    = 3'd2,
    FETCH_HI = 3'd3,
    HALT     = 3'd4
  } type_align_state_e;

  // A halfword starts a compressed instruction unless its two low bits are 2'b11.
  function automatic logic is_comp(input logic [HALF_W-1:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_align_ctrl_halfword_extract.sv
// Selects the next instruction and its length from the buffered word and straddle halfword.
module fetch_align_ctrl_halfword_extract
  import fetch_align_ctrl_pkg::*;
(
  input  logic [ILEN-1:0]   line,
  input  logic [HALF_W-1:0] hbuf,
  input  logic              sel_hi,
  input  logic              straddle,
  output logic [ILEN-1:0]   instr_c,
  output logic              comp_c
);

  logic [HALF_W-1:0] half;

  // Straddle joins the saved low half with the new word; otherwise pick the half at pc[1].
  always_comb begin
    half    = sel_hi ? line[31:16] : line[15:0];
    instr_c = line;
    comp_c  = 1'b0;
    if (straddle) begin
      instr_c = {line[15:0], hbuf};
    end else if (is_comp(half)) begin
      instr_c = {16'h0000, half};
      comp_c  = 1'b1;
    end
  end

endmodule

// File: rtl/fetch_align_ctrl.sv
// Fetch-side sequencer: word fetches, halfword alignment, and redirect handling for RVC.
module fetch_align_ctrl
  import fetch_align_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            fetch_req_o,
  output logic [XLEN-1:0] fetch_addr_o,
  output logic            fetch_kill_o,
  input  logic            fetch_ack_i,
  input  logic [ILEN-1:0] fetch_data_i,
  input  logic            fetch_err_i,
  output logic            instr_valid_o,
  input  logic            id_ready_i,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic [XLEN-1:0] instr_pc_next_o,
  output logic            is_comp_o,
  output logic            instr_fault_o
);

  localparam int unsigned WORD_W = XLEN - 2;

  type_align_state_e state_q;
  logic [XLEN-1:0]   pc_q;
  logic [ILEN-1:0]   line_q;
  logic [WORD_W-1:0] line_addr_q;
  logic              line_vld_q;
  logic [HALF_W-1:0] hbuf_q;
  logic              hb_vld_q;
  logic              fault_pend_q;

  logic [WORD_W-1:0] pc_word;
  logic [WORD_W-1:0] pc_word_inc;
  logic [XLEN-1:0]   redir_pc;
  logic [XLEN-1:0]   pc_step;
  logic [ILEN-1:0]   ex_instr;
  logic              ex_comp;
  logic              hit;
  logic              strad_hit;
  logic              can_issue;
  logic              slot_free;

  assign pc_word     = pc_q[XLEN-1:2];
  assign pc_word_inc = pc_word + WORD_W'(1);
  assign redir_pc    = redirect_pc_i & ~XLEN'(1);
  assign hit         = line_vld_q && (line_addr_q == pc_word);
  assign strad_hit   = !hit && pc_q[1] && hb_vld_q && line_vld_q && (line_addr_q == pc_word_inc);
  // Low-half hits always issue; upper-half hits issue only when compressed.
  assign can_issue   = (hit && (!pc_q[1] || ex_comp)) || strad_hit;
  assign slot_free   = !instr_valid_o || id_ready_i;
  assign pc_step     = pc_q + (ex_comp ? XLEN'(2) : XLEN'(4));
  // Kill is only meaningful while a request is outstanding.
  assign fetch_kill_o = redirect_i && fetch_req_o;

  fetch_align_ctrl_halfword_extract u_extract (
    .line     (line_q),
    .hbuf     (hbuf_q),
    .sel_hi   (pc_q[1]),
    .straddle (strad_hit),
    .instr_c  (ex_instr),
    .comp_c   (ex_comp)
  );

  // Sequencer: redirect wins, then per-state fetch/issue with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      pc_q            <= PC_RESET;
      line_q          <= '0;
      line_addr_q     <= '0;
      line_vld_q      <= 1'b0;
      hbuf_q          <= '0;
      hb_vld_q        <= 1'b0;
      fault_pend_q    <= 1'b0;
      fetch_req_o     <= 1'b0;
      fetch_addr_o    <= '0;
      instr_valid_o   <= 1'b0;
      instr_o         <= '0;
      instr_pc_o      <= '0;
      instr_pc_next_o <= '0;
      is_comp_o       <= 1'b0;
      instr_fault_o   <= 1'b0;
    end else if (redirect_i) begin
      state_q         <= FETCH;
      pc_q            <= redir_pc;
      line_vld_q      <= 1'b0;
      hb_vld_q        <= 1'b0;
      fault_pend_q    <= 1'b0;
      fetch_req_o     <= 1'b1;
      fetch_addr_o    <= {redir_pc[XLEN-1:2], 2'b00};
      instr_valid_o   <= 1'b0;
      instr_o         <= '0;
      instr_pc_o      <= '0;
      instr_pc_next_o <= '0;
      is_comp_o       <= 1'b0;
      instr_fault_o   <= 1'b0;
    end else begin
      if (instr_valid_o && id_ready_i) begin
        instr_valid_o <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          state_q      <= FETCH;
          fetch_req_o  <= 1'b1;
          fetch_addr_o <= {pc_word, 2'b00};
        end
        RUN: begin
          if (can_issue) begin
            if (slot_free) begin
              instr_valid_o   <= 1'b1;
              instr_o         <= ex_instr;
              instr_pc_o      <= pc_q;
              instr_pc_next_o <= pc_step;
              is_comp_o       <= ex_comp;
              instr_fault_o   <= 1'b0;
              pc_q            <= pc_step;
              if (strad_hit) begin
                hb_vld_q <= 1'b0;
              end
            end
          end else if (hit) begin
            hbuf_q       <= line_q[31:16];
            hb_vld_q     <= 1'b1;
            state_q      <= FETCH_HI;
            fetch_req_o  <= 1'b1;
            fetch_addr_o <= {pc_word_inc, 2'b00};
          end else begin
            hb_vld_q     <= 1'b0;
            state_q      <= FETCH;
            fetch_req_o  <= 1'b1;
            fetch_addr_o <= {pc_word, 2'b00};
          end
        end
        FETCH, FETCH_HI: begin
          if (fetch_ack_i) begin
            fetch_req_o <= 1'b0;
            if (fetch_err_i) begin
              line_vld_q <= 1'b0;
              hb_vld_q   <= 1'b0;
              state_q    <= HALT;
              if (slot_free) begin
                instr_valid_o   <= 1'b1;
                instr_o         <= INSTR_NOP;
                instr_pc_o      <= pc_q;
                instr_pc_next_o <= pc_q + XLEN'(4);
                is_comp_o       <= 1'b0;
                instr_fault_o   <= 1'b1;
              end else begin
                fault_pend_q <= 1'b1;
              end
            end else begin
              line_q      <= fetch_data_i;
              line_addr_q <= fetch_addr_o[XLEN-1:2];
              line_vld_q  <= 1'b1;
              state_q     <= RUN;
            end
          end
        end
        HALT: begin
          if (fault_pend_q && slot_free) begin
            fault_pend_q    <= 1'b0;
            instr_valid_o   <= 1'b1;
            instr_o         <= INSTR_NOP;
            instr_pc_o      <= pc_q;
            instr_pc_next_o <= pc_q + XLEN'(4);
            is_comp_o       <= 1'b0;
            instr_fault_o   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_align_ctrl.sv
// Directed bench for fetch_align_ctrl with hand-computed expectations.
module tb_fetch_align_ctrl;

  logic        clk;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        fetch_req_o;
  logic [31:0] fetch_addr_o;
  logic        fetch_kill_o;
  logic        fetch_ack_i;
  logic [31:0] fetch_data_i;
  logic        fetch_err_i;
  logic        instr_valid_o;
  logic        id_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic [31:0] instr_pc_next_o;
  logic        is_comp_o;
  logic        instr_fault_o;

  int checks = 0;
  int errors = 0;

  fetch_align_ctrl #(
    .XLEN     (32),
    .PC_RESET (32'h0000_1000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .fetch_req_o     (fetch_req_o),
    .fetch_addr_o    (fetch_addr_o),
    .fetch_kill_o    (fetch_kill_o),
    .fetch_ack_i     (fetch_ack_i),
    .fetch_data_i    (fetch_data_i),
    .fetch_err_i     (fetch_err_i),
    .instr_valid_o   (instr_valid_o),
    .id_ready_i      (id_ready_i),
    .instr_o         (instr_o),
    .instr_pc_o      (instr_pc_o),
    .instr_pc_next_o (instr_pc_next_o),
    .is_comp_o       (is_comp_o),
    .instr_fault_o   (instr_fault_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic [31:0] exp_addr, input string tag);
    int n = 0;
    while (!fetch_req_o && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, 32'(fetch_req_o), 32'd1);
    chk({tag, "_addr"}, fetch_addr_o, exp_addr);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!instr_valid_o && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(instr_valid_o), 32'd1);
  endtask

  task automatic ack_word(input logic [31:0] data, input logic err);
    fetch_ack_i  = 1'b1;
    fetch_data_i = data;
    fetch_err_i  = err;
    tick();
    fetch_ack_i  = 1'b0;
    fetch_err_i  = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_i    = 1'b1;
    redirect_pc_i = pc;
    tick();
    redirect_i    = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] pcn, input logic comp);
    chk({tag, "_valid"}, 32'(instr_valid_o), 32'd1);
    chk({tag, "_instr"}, instr_o, ins);
    chk({tag, "_pc"}, instr_pc_o, pc);
    chk({tag, "_pcnext"}, instr_pc_next_o, pcn);
    chk({tag, "_comp"}, 32'(is_comp_o), 32'(comp));
  endtask

  initial begin
    int nreq;
    logic prev_req;

    rst           = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_5000;
    fetch_ack_i   = 1'b0;
    fetch_data_i  = '0;
    fetch_err_i   = 1'b0;
    id_ready_i    = 1'b1;

    // Reset: all outputs low, redirect ignored
    tick();
    tick();
    chk("rst_req", 32'(fetch_req_o), 32'd0);
    chk("rst_kill", 32'(fetch_kill_o), 32'd0);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_fault", 32'(instr_fault_o), 32'd0);
    chk("rst_addr", fetch_addr_o, 32'd0);
    redirect_i = 1'b0;
    rst        = 1'b0;

    // Aligned fetch from PC_RESET
    wait_req(32'h0000_1000, "s1_first");
    ack_word(32'h0000_0013, 1'b0);
    chk("s1_no_valid_yet", 32'(instr_valid_o), 32'd0);
    tick();
    chk_out("s1_out", 32'h0000_0013, 32'h0000_1000, 32'h0000_1004, 1'b0);
    tick();
    chk("s1_consumed", 32'(instr_valid_o), 32'd0);
    wait_req(32'h0000_1004, "s1_next");

    // Two compressed instructions from one word
    redirect(32'h0000_1000);
    wait_req(32'h0000_1000, "s2");
    ack_word(32'h4505_0001, 1'b0);
    tick();
    chk_out("s2_c0", 32'h0000_0001, 32'h0000_1000, 32'h0000_1002, 1'b1);
    chk("s2_c0_noreq", 32'(fetch_req_o), 32'd0);
    tick();
    chk_out("s2_c1", 32'h0000_4505, 32'h0000_1002, 32'h0000_1004, 1'b1);
    chk("s2_c1_noreq", 32'(fetch_req_o), 32'd0);
    tick();
    chk("s2_next_addr", fetch_addr_o, 32'h0000_1004);

    // Straddling 32-bit instruction
    redirect(32'h0000_1000);
    wait_req(32'h0000_1000, "s3");
    ack_word(32'h0093_0001, 1'b0);
    tick();
    chk_out("s3_c0", 32'h0000_0001, 32'h0000_1000, 32'h0000_1002, 1'b1);
    wait_req(32'h0000_1004, "s3_hi");
    ack_word(32'hABCD_0010, 1'b0);
    tick();
    chk_out("s3_strad", 32'h0010_0093, 32'h0000_1002, 32'h0000_1006, 1'b0);
    chk("s3_strad_noreq", 32'(fetch_req_o), 32'd0);
    tick();
    chk_out("s3_tail", 32'h0000_ABCD, 32'h0000_1006, 32'h0000_1008, 1'b1);
    chk("s3_tail_noreq", 32'(fetch_req_o), 32'd0);

    // Redirect while a fetch is pending, with a same-cycle ack
    redirect(32'h0000_1000);
    wait_req(32'h0000_1000, "s4_pend");
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_2002;
    fetch_ack_i   = 1'b1;
    fetch_data_i  = 32'hDEAD_BEEF;
    #1;
    chk("s4_kill", 32'(fetch_kill_o), 32'd1);
    tick();
    redirect_i  = 1'b0;
    fetch_ack_i = 1'b0;
    chk("s4_valid_clr", 32'(instr_valid_o), 32'd0);
    wait_req(32'h0000_2000, "s4_new");
    ack_word(32'h4505_0001, 1'b0);
    tick();
    chk_out("s4_out", 32'h0000_4505, 32'h0000_2002, 32'h0000_2004, 1'b1);

    // Backpressure for 5 cycles
    redirect(32'h0000_1000);
    id_ready_i = 1'b0;
    wait_req(32'h0000_1000, "s5");
    ack_word(32'h4505_0001, 1'b0);
    tick();
    chk_out("s5_first", 32'h0000_0001, 32'h0000_1000, 32'h0000_1002, 1'b1);
    nreq     = 0;
    prev_req = fetch_req_o;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (fetch_req_o && !prev_req) nreq++;
      prev_req = fetch_req_o;
      chk($sformatf("s5_hold%0d_instr", i), instr_o, 32'h0000_0001);
      chk($sformatf("s5_hold%0d_pc", i), instr_pc_o, 32'h0000_1000);
      chk($sformatf("s5_hold%0d_valid", i), 32'(instr_valid_o), 32'd1);
    end
    chk("s5_extra_fetch_le1", 32'(nreq <= 1), 32'd1);
    id_ready_i = 1'b1;
    tick();
    chk_out("s5_resume", 32'h0000_4505, 32'h0000_1002, 32'h0000_1004, 1'b1);

    // Fetch fault halts fetching until a redirect
    redirect(32'h0000_3000);
    wait_req(32'h0000_3000, "s6");
    ack_word(32'h1234_5678, 1'b1);
    wait_valid("s6_fault");
    chk("s6_fault_flag", 32'(instr_fault_o), 32'd1);
    chk("s6_fault_instr", instr_o, 32'h0000_0013);
    chk("s6_fault_pc", instr_pc_o, 32'h0000_3000);
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (fetch_req_o) nreq++;
    end
    chk("s6_halt_no_fetch", 32'(nreq), 32'd0);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_1000;
    #1;
    chk("s6_kill_idle", 32'(fetch_kill_o), 32'd0);
    tick();
    redirect_i = 1'b0;
    chk("s6_fault_clr", 32'(instr_fault_o), 32'd0);
    wait_req(32'h0000_1000, "s6_recover");

    // Straddle across the top of the address space wraps to word 0
    redirect(32'hFFFF_FFFF);
    wait_req(32'hFFFF_FFFC, "s7");
    ack_word(32'h0093_0001, 1'b0);
    wait_req(32'h0000_0000, "s7_wrap");
    ack_word(32'h0000_0010, 1'b0);
    tick();
    chk_out("s7_out", 32'h0010_0093, 32'hFFFF_FFFE, 32'h0000_0002, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case a sequence step never returns.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
